// File: rtl/img2col_sipo_loader.sv
// img2col serial-in / parallel-out window loader.
// Packs REG_NUM pixels into a vector held until the consumer acknowledges it.
module img2col_sipo_loader #(
  parameter  int DATA_WIDTH = 16,
  parameter  int REG_NUM    = 20,
  localparam int CW         = $clog2(REG_NUM + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] out_vec [REG_NUM],
  output logic                  out_valid,
  input  logic                  out_ack,
  output logic [CW-1:0]         fill_cnt,
  output logic                  padded
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_vec [REG_NUM];
  logic [CW-1:0]         r_fill_cnt;
  logic                  r_out_valid;
  logic                  r_in_ready;
  logic                  r_padded;

  logic                  w_beat;
  logic                  w_last;
  logic [CW-1:0]         w_eff;
  logic                  w_flush_act;

  assign w_beat = in_valid & r_in_ready;
  assign w_last = (r_fill_cnt == CW'(REG_NUM - 1));
  assign w_eff  = r_fill_cnt + CW'(w_beat);

  // Empty vectors are never emitted; a beat in the same cycle counts.
  assign w_flush_act = flush
                     & (r_state == S_FILL)
                     & (w_eff != '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_FILL;
      r_fill_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_padded    <= 1'b0;
      for (int i = 0; i < REG_NUM; i++) begin
        r_vec[i] <= '0;
      end
    end else begin
      unique case (r_state)
        S_FILL: begin
          for (int i = 0; i < REG_NUM; i++) begin
            if (w_beat && (r_fill_cnt == CW'(i))) begin
              r_vec[i] <= in_data;
            end else if (w_flush_act && (CW'(i) >= w_eff)) begin
              r_vec[i] <= '0;
            end
          end
          r_in_ready <= 1'b1;
          if (w_beat && w_last) begin
            r_state     <= S_FULL;
            r_fill_cnt  <= CW'(REG_NUM);
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
            r_padded    <= 1'b0;
          end else if (w_flush_act) begin
            r_state     <= S_FULL;
            r_fill_cnt  <= w_eff;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
            r_padded    <= 1'b1;
          end else begin
            r_fill_cnt  <= w_eff;
          end
        end
        S_FULL: begin
          // Vector stays frozen past the PIPO negedge sample of the ack cycle.
          if (out_ack) begin
            r_state     <= S_FILL;
            r_fill_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_padded    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

  assign out_vec   = r_vec;
  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign fill_cnt  = r_fill_cnt;
  assign padded    = r_padded;

endmodule
